cmp_result_monitor: RTL and testbench

- Sequential stage directly downstream of the 4-bit comparator.
- Accepts one comparator result (eq/gt/sm) per cycle under a valid strobe and checks that exactly one flag is set.
- Tracks runs of consecutive A>B or A<B results and raises a latched alarm when a run reaches STREAK_LEN.
- Feeds the status/interrupt logic.

---
 rtl/cmp_result_monitor.sv | 167 ++++++++++++++++
 tb/tb_cmp_result_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor
//
// Sits directly behind the 4-bit magnitude comparator. Each cycle it may
// accept one comparator result (eq / gt / sm) under in_valid. It checks that
// exactly one flag is set, tracks runs of consecutive same-direction results
// (A>B or A<B), and raises a latched alarm once a run reaches STREAK_LEN.
// The outputs feed the status/interrupt logic.
//
// Configuration macro: CMP_STATS_EN
//   defined   -> saturating per-type tally counters are built
//   undefined -> gt_cnt / eq_cnt / sm_cnt are tied to 0 (ports remain)
//
// Parameters:
//   STREAK_LEN  run length that trips the alarm, legal 1..15
//   CNT_W       width of the tally counters
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   eq/gt/sm carry a new result this cycle
//   eq/gt/sm   comparator flags (A==B, A>B, A<B)
//   clr        synchronous clear of alarm, err, streak and counters
//   out_valid  one-cycle pulse: an accepted result was processed
//   alarm      latched streak alarm
//   alarm_dir  direction of the alarm run: 1 = gt run, 0 = sm run
//   streak     current run length
//   err        sticky flag: a non-one-hot result was presented
//   gt_cnt     saturating count of accepted gt results
//   eq_cnt     saturating count of accepted eq results
//   sm_cnt     saturating count of accepted sm results

module cmp_result_monitor #(
    parameter int STREAK_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             sm,
    input  logic             clr,
    output logic             out_valid,
    output logic             alarm,
    output logic             alarm_dir,
    output logic [3:0]       streak,
    output logic             err,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] sm_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_GT = 2'd1,
        RUN_SM = 2'd2,
        ALARM  = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STREAK_LEN);

    state_t     state;
    logic       one_hot;
    logic       accept;
    logic       reject;
    logic [3:0] gt_len;
    logic [3:0] sm_len;

    // A sample is only looked at when clr is low; clr drops it entirely.
    always_comb begin
        one_hot = 1'b0;
        case ({eq, gt, sm})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
        accept = in_valid & ~clr & one_hot;
        reject = in_valid & ~clr & ~one_hot;
    end

    // Run length the incoming sample would produce: it extends the current
    // run when the direction matches, otherwise it starts a new run of 1.
    always_comb begin
        gt_len = (state == RUN_GT) ? streak + 4'd1 : 4'd1;
        sm_len = (state == RUN_SM) ? streak + 4'd1 : 4'd1;
    end

    // Run-tracking FSM with registered outputs. ALARM is absorbing: only
    // clr or reset leaves it, so alarm/alarm_dir/streak hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alarm     <= 1'b0;
            alarm_dir <= 1'b0;
            streak    <= 4'd0;
            err       <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alarm     <= 1'b0;
            alarm_dir <= 1'b0;
            streak    <= 4'd0;
            err       <= 1'b0;
        end else begin
            out_valid <= accept;
            if (reject) begin
                err <= 1'b1;
            end
            if (accept && state != ALARM) begin
                if (eq) begin
                    state  <= IDLE;
                    streak <= 4'd0;
                end else if (gt) begin
                    streak <= gt_len;
                    if (gt_len == STREAK_MAX) begin
                        state     <= ALARM;
                        alarm     <= 1'b1;
                        alarm_dir <= 1'b1;
                    end else begin
                        state <= RUN_GT;
                    end
                end else begin
                    streak <= sm_len;
                    if (sm_len == STREAK_MAX) begin
                        state     <= ALARM;
                        alarm     <= 1'b1;
                        alarm_dir <= 1'b0;
                    end else begin
                        state <= RUN_SM;
                    end
                end
            end
        end
    end

`ifdef CMP_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-type tallies of accepted samples; they stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            sm_cnt <= '0;
        end else if (clr) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            sm_cnt <= '0;
        end else if (accept) begin
            if (gt && gt_cnt != CNT_MAX) begin
                gt_cnt <= gt_cnt + CNT_W'(1);
            end
            if (eq && eq_cnt != CNT_MAX) begin
                eq_cnt <= eq_cnt + CNT_W'(1);
            end
            if (sm && sm_cnt != CNT_MAX) begin
                sm_cnt <= sm_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign gt_cnt = '0;
    assign eq_cnt = '0;
    assign sm_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor
//
// Directed bench for cmp_result_monitor (STREAK_LEN=4, CNT_W=8). A
// behavioural model tracks the expected outputs in terms of "current run
// direction and length", "alarm latched" and plain integer tallies; a
// compare process checks every DUT output against it each cycle. Literal
// expectations in the stimulus sequence pin the model itself.

module tb_cmp_result_monitor;

    localparam int STREAK_LEN = 4;
    localparam int CNT_W      = 8;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;
`ifdef CMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             eq;
    logic             gt;
    logic             sm;
    logic             clr;
    logic             out_valid;
    logic             alarm;
    logic             alarm_dir;
    logic [3:0]       streak;
    logic             err;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] sm_cnt;

    int total_checks;
    int bad_checks;

    // Model state
    int m_run_len;
    bit m_run_gt;
    bit m_alarm;
    bit m_alarm_dir;
    bit m_err;
    bit m_ov;
    int m_gt;
    int m_eq;
    int m_sm;

    cmp_result_monitor #(
        .STREAK_LEN(STREAK_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .eq       (eq),
        .gt       (gt),
        .sm       (sm),
        .clr      (clr),
        .out_valid(out_valid),
        .alarm    (alarm),
        .alarm_dir(alarm_dir),
        .streak   (streak),
        .err      (err),
        .gt_cnt   (gt_cnt),
        .eq_cnt   (eq_cnt),
        .sm_cnt   (sm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int satInc(int v);
        return (v >= CNT_SAT) ? CNT_SAT : v + 1;
    endfunction

    // Model: what the outputs must be after each edge, from the rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run_len = 0; m_run_gt = 0; m_alarm = 0; m_alarm_dir = 0;
            m_err = 0; m_ov = 0; m_gt = 0; m_eq = 0; m_sm = 0;
        end else begin
            m_ov = 0;
            if (clr) begin
                m_run_len = 0; m_run_gt = 0; m_alarm = 0; m_alarm_dir = 0;
                m_err = 0; m_gt = 0; m_eq = 0; m_sm = 0;
            end else if (in_valid) begin
                if (int'(eq) + int'(gt) + int'(sm) != 1) begin
                    m_err = 1;
                end else begin
                    m_ov = 1;
                    if (STATS) begin
                        if (gt) m_gt = satInc(m_gt);
                        if (eq) m_eq = satInc(m_eq);
                        if (sm) m_sm = satInc(m_sm);
                    end
                    if (!m_alarm) begin
                        if (eq) begin
                            m_run_len = 0;
                        end else if (m_run_len > 0 && m_run_gt == gt) begin
                            m_run_len++;
                        end else begin
                            m_run_len = 1;
                            m_run_gt  = gt;
                        end
                        if (m_run_len >= STREAK_LEN) begin
                            m_alarm     = 1;
                            m_alarm_dir = m_run_gt;
                        end
                    end
                end
            end
        end
    end

    task automatic checkValue(string name, int actual, int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("out_valid", int'(out_valid), int'(m_ov));
        checkValue("alarm", int'(alarm), int'(m_alarm));
        checkValue("alarm_dir", int'(alarm_dir), int'(m_alarm_dir));
        checkValue("streak", int'(streak), m_run_len);
        checkValue("err", int'(err), int'(m_err));
        checkValue("gt_cnt", int'(gt_cnt), m_gt);
        checkValue("eq_cnt", int'(eq_cnt), m_eq);
        checkValue("sm_cnt", int'(sm_cnt), m_sm);
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) checkOutput();
    end

    // Drive one cycle of inputs, let the edge consume them, then idle.
    task automatic applyStimulus(bit v, bit e, bit g, bit s, bit c);
        @(negedge clk);
        in_valid = v; eq = e; gt = g; sm = s; clr = c;
        @(posedge clk);
        #1;
        in_valid = 0; eq = 0; gt = 0; sm = 0; clr = 0;
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        in_valid = 0; eq = 0; gt = 0; sm = 0; clr = 0;
        rst_n = 0;
        #12;
        checkValue("reset_streak", int'(streak), 0);
        checkValue("reset_alarm", int'(alarm), 0);
        @(negedge clk);
        #2 rst_n = 1;

        // gt run reaching the alarm
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0, 1, 0, 0);
            checkValue("gt_run_streak", int'(streak), i);
            checkValue("gt_run_ov", int'(out_valid), 1);
            checkValue("gt_run_alarm", int'(alarm), (i == 4) ? 1 : 0);
        end
        checkValue("gt_alarm_dir", int'(alarm_dir), 1);
        // held in ALARM; counters still move
        applyStimulus(1, 0, 0, 1, 0);
        checkValue("alarm_hold_streak", int'(streak), 4);
        checkValue("alarm_hold_dir", int'(alarm_dir), 1);
        checkValue("alarm_hold_gtcnt", int'(gt_cnt), STATS ? 4 : 0);
        checkValue("alarm_hold_smcnt", int'(sm_cnt), STATS ? 1 : 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkValue("clr_alarm", int'(alarm), 0);
        checkValue("clr_gtcnt", int'(gt_cnt), 0);

        // run broken by eq
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkValue("brk_streak3", int'(streak), 3);
        applyStimulus(1, 1, 0, 0, 0);
        checkValue("brk_streak_eq", int'(streak), 0);
        applyStimulus(1, 0, 0, 1, 0);
        checkValue("brk_streak_sm", int'(streak), 1);
        checkValue("brk_alarm", int'(alarm), 0);

        // invalid samples: discarded, err sticky
        applyStimulus(1, 1, 1, 0, 0);
        checkValue("inv_err", int'(err), 1);
        checkValue("inv_ov", int'(out_valid), 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkValue("inv_streak", int'(streak), 1);
        checkValue("inv_eqcnt", int'(eq_cnt), STATS ? 1 : 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkValue("idle_ov", int'(out_valid), 0);
        checkValue("err_sticky", int'(err), 1);

        // sm run continues to alarm, then clr collides with gt
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0);
        checkValue("sm_alarm", int'(alarm), 1);
        checkValue("sm_alarm_dir", int'(alarm_dir), 0);
        checkValue("sm_streak", int'(streak), 4);
        applyStimulus(1, 0, 1, 0, 1);
        checkValue("clr_col_alarm", int'(alarm), 0);
        checkValue("clr_col_err", int'(err), 0);
        checkValue("clr_col_gtcnt", int'(gt_cnt), 0);
        checkValue("clr_col_ov", int'(out_valid), 0);

        // asynchronous reset mid-cycle with pending state
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        #2 rst_n = 0;
        #1;
        checkValue("async_streak", int'(streak), 0);
        checkValue("async_gtcnt", int'(gt_cnt), 0);
        checkValue("async_ov", int'(out_valid), 0);
        @(negedge clk);
        #2 rst_n = 1;
        applyStimulus(1, 0, 1, 0, 0);
        checkValue("post_reset_streak", int'(streak), 1);

        // mixed table with flips and eq breaks
        for (int i = 0; i < 12; i++) begin
            case (i % 4)
                0: applyStimulus(1, 0, 0, 1, 0);
                1: applyStimulus(1, 0, 1, 0, 0);
                2: applyStimulus(1, 0, 1, 0, 0);
                default: applyStimulus(1, 1, 0, 0, 0);
            endcase
        end
        checkValue("mix_alarm", int'(alarm), 0);

        // eq tally saturation
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 0, 0);
        checkValue("sat_eqcnt", int'(eq_cnt), STATS ? 255 : 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkValue("sat_hold", int'(eq_cnt), STATS ? 255 : 0);
        checkValue("sat_streak", int'(streak), 0);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
